ffe_coeff_bank: RTL and testbench

FFE_COEFF_BANK -- requirements
Module: ffe_coeff_bank

---
 rtl/ffe_coeff_bank.sv | 170 +++++++++++++++++
 tb/tb_ffe_coeff_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_coeff_bank.sv
// ffe_coeff_bank: FFE tap register bank fed by an adaptation engine through an update divider,
// with single-tap host access. Build macro FFE_COEFF_CLAMP_EN enables saturation of engine commits.
module ffe_coeff_bank #(
  parameter int FFE_LEN     = 21,
  parameter int NB          = 8,
  parameter int NBF         = 7,
  parameter int INIT_CENTER = 64,
  parameter int UPDATE_DIV  = 1,
  parameter int CLAMP_MAX   = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FFE_LEN*NB-1:0] i_new_coeff,
  input  logic                  i_update_en,
  input  logic                  i_freeze,
  input  logic                  i_host_wr,
  input  logic                  i_host_rd,
  input  logic [7:0]            i_host_addr,
  input  logic [NB-1:0]         i_host_wdata,
  output logic [NB-1:0]         o_host_rdata,
  output logic                  o_host_rvalid,
  output logic [FFE_LEN*NB-1:0] o_coeff_flat,
  output logic                  o_commit,
  output logic [31:0]           o_commit_cnt,
  output logic                  o_sat_flag
);

  localparam int         CENTER   = (FFE_LEN - 1) / 2;
  localparam logic [7:0] DIV_LAST = 8'(UPDATE_DIV - 1);

  if (NBF >= NB || UPDATE_DIV < 1 || UPDATE_DIV > 255 || FFE_LEN > 256) begin : g_param_check
    $error("ffe_coeff_bank: illegal parameter combination");
  end

  logic          qualify;
  logic          commit;
  logic [7:0]    div_reg;
  logic [7:0]    div_next;
  logic          commit_reg;
  logic [31:0]   commit_cnt_reg;
  logic [NB-1:0] rdata_reg;
  logic [NB-1:0] rdata_next;
  logic          rvalid_reg;
  logic [NB-1:0] tap_arr [FFE_LEN];

  // Frozen cycles neither advance the divider nor commit.
  assign qualify = i_update_en & ~i_freeze;
  assign commit  = qualify && (div_reg == DIV_LAST);

  always_comb begin
    div_next = div_reg;
    if (qualify) begin
      div_next = commit ? 8'd0 : div_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg        <= 8'd0;
      commit_reg     <= 1'b0;
      commit_cnt_reg <= 32'd0;
    end else begin
      div_reg    <= div_next;
      commit_reg <= commit;
      if (commit) begin
        commit_cnt_reg <= commit_cnt_reg + 32'd1;
      end
    end
  end

`ifdef FFE_COEFF_CLAMP_EN
  localparam logic signed [NB:0] CMAX_POS = (NB + 1)'(CLAMP_MAX);
  localparam logic signed [NB:0] CMAX_NEG = -CMAX_POS;
  logic [FFE_LEN-1:0] clip_vec;
  logic               sat_reg;
`endif

  genvar gi;
  for (gi = 0; gi < FFE_LEN; gi++) begin : g_tap
    localparam logic [NB-1:0] RST_VAL = (gi == CENTER) ? NB'(INIT_CENTER) : '0;

    logic [NB-1:0] tap_reg;
    logic [NB-1:0] eng_raw;
    logic [NB-1:0] eng_val;
    logic          host_hit;

    assign eng_raw  = i_new_coeff[gi*NB +: NB];
    assign host_hit = i_host_wr && (i_host_addr == 8'(gi));

`ifdef FFE_COEFF_CLAMP_EN
    logic signed [NB:0] raw_ext;
    logic               eng_clip;

    assign raw_ext = {eng_raw[NB-1], eng_raw};

    always_comb begin
      eng_val  = eng_raw;
      eng_clip = 1'b0;
      if (raw_ext > CMAX_POS) begin
        eng_val  = CMAX_POS[NB-1:0];
        eng_clip = 1'b1;
      end else if (raw_ext < CMAX_NEG) begin
        eng_val  = CMAX_NEG[NB-1:0];
        eng_clip = 1'b1;
      end
    end

    // A tap overwritten by the host on the commit edge does not count as clamped.
    assign clip_vec[gi] = eng_clip & ~host_hit;
`else
    assign eng_val = eng_raw;
`endif

    // Host write wins over the engine for the addressed tap only.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tap_reg <= RST_VAL;
      end else if (host_hit) begin
        tap_reg <= i_host_wdata;
      end else if (commit) begin
        tap_reg <= eng_val;
      end
    end

    assign tap_arr[gi]                = tap_reg;
    assign o_coeff_flat[gi*NB +: NB]  = tap_reg;
  end

`ifdef FFE_COEFF_CLAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_reg <= 1'b0;
    end else if (commit && (|clip_vec)) begin
      sat_reg <= 1'b1;
    end
  end

  assign o_sat_flag = sat_reg;
`else
  assign o_sat_flag = 1'b0;
`endif

  // Read mux sees pre-edge tap contents; out-of-range addresses read as zero.
  always_comb begin
    rdata_next = '0;
    for (int k = 0; k < FFE_LEN; k++) begin
      if (i_host_addr == 8'(k)) begin
        rdata_next = tap_arr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= i_host_rd;
      if (i_host_rd) begin
        rdata_reg <= rdata_next;
      end
    end
  end

  assign o_host_rdata  = rdata_reg;
  assign o_host_rvalid = rvalid_reg;
  assign o_commit      = commit_reg;
  assign o_commit_cnt  = commit_cnt_reg;

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// Testbench for ffe_coeff_bank: directed scenarios plus randomized traffic against a tap-array model.
module tb_ffe_coeff_bank;

  localparam int FFE_LEN    = 21;
  localparam int NB         = 8;
  localparam int UPDATE_DIV = 4;
  localparam int CLAMP_MAX  = 100;
  localparam int W          = FFE_LEN * NB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   new_coeff = '0;
  logic           update_en = 1'b0;
  logic           freeze = 1'b0;
  logic           host_wr = 1'b0;
  logic           host_rd = 1'b0;
  logic [7:0]     host_addr = '0;
  logic [NB-1:0]  host_wdata = '0;
  logic [NB-1:0]  host_rdata;
  logic           host_rvalid;
  logic [W-1:0]   coeff_flat;
  logic           commit;
  logic [31:0]    commit_cnt;
  logic           sat_flag;

  always #5 clk = ~clk;

  ffe_coeff_bank #(
    .FFE_LEN(FFE_LEN), .NB(NB), .NBF(7), .INIT_CENTER(64),
    .UPDATE_DIV(UPDATE_DIV), .CLAMP_MAX(CLAMP_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_new_coeff(new_coeff), .i_update_en(update_en),
    .i_freeze(freeze), .i_host_wr(host_wr), .i_host_rd(host_rd), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_rdata(host_rdata), .o_host_rvalid(host_rvalid),
    .o_coeff_flat(coeff_flat), .o_commit(commit), .o_commit_cnt(commit_cnt), .o_sat_flag(sat_flag)
  );

  int checks = 0;
  int failures = 0;
  int pulses;

  // Reference model: plain integer taps and an update counter
  int            m_tap [FFE_LEN];
  int            m_div;
  logic [31:0]   m_cnt;
  bit            m_commit, m_rvalid, m_sat;
  logic [NB-1:0] m_rdata;

  function automatic int sx(input logic [NB-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [W-1:0] all_taps(input int v);
    logic [W-1:0] f;
    for (int k = 0; k < FFE_LEN; k++) f[k*NB +: NB] = NB'(v);
    return f;
  endfunction

  function automatic logic [W-1:0] rand_flat();
    logic [W-1:0] f;
    for (int k = 0; k < FFE_LEN; k++) f[k*NB +: NB] = NB'($urandom);
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < FFE_LEN; k++) m_tap[k] = (k == (FFE_LEN - 1) / 2) ? 64 : 0;
    m_div = 0; m_cnt = 0; m_commit = 0; m_rvalid = 0; m_sat = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit q, com, clipped;
    int nt [FFE_LEN];
    int v;
    q   = update_en && !freeze;
    com = q && (m_div == UPDATE_DIV - 1);
    m_rvalid = host_rd;
    if (host_rd) m_rdata = (host_addr < FFE_LEN) ? NB'(m_tap[host_addr]) : '0;
    nt = m_tap;
    if (q) m_div = com ? 0 : m_div + 1;
    if (com) begin
      m_cnt = m_cnt + 1;
      for (int k = 0; k < FFE_LEN; k++) begin
        v = sx(new_coeff[k*NB +: NB]);
        clipped = 0;
`ifdef FFE_COEFF_CLAMP_EN
        if (v > CLAMP_MAX) begin v = CLAMP_MAX; clipped = 1; end
        else if (v < -CLAMP_MAX) begin v = -CLAMP_MAX; clipped = 1; end
`endif
        if (!(host_wr && host_addr == 8'(k))) begin
          nt[k] = v;
          if (clipped) m_sat = 1;
        end
      end
    end
    if (host_wr && host_addr < FFE_LEN) nt[host_addr] = sx(host_wdata);
    m_commit = com;
    m_tap = nt;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] ef;
    for (int k = 0; k < FFE_LEN; k++) ef[k*NB +: NB] = NB'(m_tap[k]);
    chk("coeff_flat", coeff_flat, ef);
    chk("commit", W'(commit), W'(m_commit));
    chk("commit_cnt", W'(commit_cnt), W'(m_cnt));
    chk("rvalid", W'(host_rvalid), W'(m_rvalid));
    chk("rdata", W'(host_rdata), W'(m_rdata));
    chk("sat_flag", W'(sat_flag), W'(m_sat));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    pulses += int'(commit);
  endtask

  task automatic idle();
    update_en = 0; freeze = 0; host_wr = 0; host_rd = 0;
  endtask

  task automatic advance_div_to(input int target);
    idle();
    while (m_div != target) begin
      update_en = 1; new_coeff = rand_flat();
      cycle();
    end
    idle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    pulses = 0;
    cycle();
    chk("rst_center_tap", W'(coeff_flat[10*NB +: NB]), W'(64));
    chk("rst_tap0", W'(coeff_flat[0 +: NB]), W'(0));
    chk("rst_cnt", W'(commit_cnt), W'(0));

    // Divided commits: 8 qualifying cycles -> 2 commits
    pulses = 0;
    update_en = 1; new_coeff = all_taps(5);
    repeat (8) cycle();
    idle();
    chk("div_pulses", W'(pulses), W'(2));
    chk("div_cnt", W'(commit_cnt), W'(2));
    chk("div_taps", coeff_flat, all_taps(5));

    // Freeze holds divider and taps
    advance_div_to(2);
    pulses = 0;
    freeze = 1; update_en = 1;
    repeat (10) begin new_coeff = rand_flat(); cycle(); end
    chk("freeze_pulses", W'(pulses), W'(0));
    freeze = 0; update_en = 1; new_coeff = all_taps(7);
    cycle();
    chk("unfreeze_no_commit", W'(commit), W'(0));
    cycle();
    chk("unfreeze_commit", W'(commit), W'(1));
    idle();

    // Host write coincident with commit
    advance_div_to(3);
    update_en = 1; new_coeff = all_taps(9);
    host_wr = 1; host_addr = 8'd3; host_wdata = NB'(-7);
    cycle();
    idle();
    chk("coinc_tap3", W'(coeff_flat[3*NB +: NB]), W'(8'hF9));
    chk("coinc_tap4", W'(coeff_flat[4*NB +: NB]), W'(9));
    chk("coinc_commit", W'(commit), W'(1));
    host_rd = 1; host_addr = 8'd3;
    cycle();
    idle();
    chk("rd3_data", W'(host_rdata), W'(8'hF9));
    chk("rd3_valid", W'(host_rvalid), W'(1));
    cycle();
    chk("rd3_valid_drop", W'(host_rvalid), W'(0));

    // Out-of-range host access
    host_rd = 1; host_addr = 8'd25;
    cycle();
    chk("rd25_data", W'(host_rdata), W'(0));
    chk("rd25_valid", W'(host_rvalid), W'(1));
    idle();
    host_wr = 1; host_addr = 8'd25; host_wdata = 8'h55;
    cycle();
    idle();

    // Clamp behaviour on tap 0 = -128
    advance_div_to(3);
    update_en = 1; new_coeff = all_taps(1); new_coeff[0 +: NB] = 8'h80;
    cycle();
    idle();
`ifdef FFE_COEFF_CLAMP_EN
    chk("clamp_tap0", W'(coeff_flat[0 +: NB]), W'(NB'(-100)));
    chk("clamp_sat", W'(sat_flag), W'(1));
`else
    chk("noclamp_tap0", W'(coeff_flat[0 +: NB]), W'(8'h80));
    chk("noclamp_sat", W'(sat_flag), W'(0));
`endif
    update_en = 1; new_coeff = all_taps(3);
    repeat (UPDATE_DIV) cycle();
    idle();

    // Randomized mixed traffic
    repeat (400) begin
      update_en  = ($urandom_range(0, 1) == 1);
      freeze     = ($urandom_range(0, 4) == 0);
      host_wr    = ($urandom_range(0, 3) == 0);
      host_rd    = ($urandom_range(0, 3) == 0);
      host_addr  = 8'($urandom_range(0, 30));
      host_wdata = NB'($urandom);
      new_coeff  = rand_flat();
      cycle();
    end
    idle();

    // Asynchronous reset mid-operation discards pending read and divider progress
    advance_div_to(2);
    update_en = 1; host_rd = 1; host_addr = 8'd5; new_coeff = rand_flat();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;
    idle();
    pulses = 0;
    update_en = 1;
    repeat (UPDATE_DIV - 1) begin new_coeff = rand_flat(); cycle(); end
    chk("post_rst_no_commit", W'(pulses), W'(0));
    new_coeff = rand_flat();
    cycle();
    chk("post_rst_commit", W'(commit), W'(1));
    chk("post_rst_cnt", W'(commit_cnt), W'(1));
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
